// File: rtl/req_encoder.sv
// req_encoder: pulsed one-hot/multi-hot requests are captured into sticky
// pending bits and handed out one index per valid/ready handshake.
// Build option: define RR_ARB_EN for round-robin selection; otherwise the
// lowest pending index wins (fixed priority). Ports and latency match in both.
module req_encoder #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [W-1:0] code_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         drop_o,
  output logic         busy_o
);

  logic [N-1:0] r_pend;
  logic [W-1:0] r_code;
  logic         r_valid;
  logic         r_drop;
`ifdef RR_ARB_EN
  logic [W-1:0] r_ptr;
`endif

  logic [W-1:0] w_sel;
  logic         w_found;
  logic         w_load;
  logic [N-1:0] w_clr;
  logic [N-1:0] w_set;

  // Pick the winning pending bit; the search order depends on the build.
  always_comb begin : sel_search
    logic [W-1:0] idx;
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_sel   = '0;
    w_found = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
`ifdef RR_ARB_EN
      idx = r_ptr + W'(k);  // wraps modulo N because N is a power of two
`else
      idx = W'(k);
`endif
      if (!w_found && r_pend[idx]) begin
        w_sel   = idx;
        w_found = 1'b1;
      end
    end
  end

  // A new code is loaded whenever something is pending and the output slot
  // is empty or being emptied this cycle; the loaded bit is cleared.
  always_comb begin
    w_load = (|r_pend) && (!r_valid || ready_i);
    w_clr  = w_load ? (N'(1) << w_sel) : '0;
    w_set  = en ? req : '0;
  end

  // State update: pending capture (set beats clear), handshake, drop pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      r_pend  <= '0;
      r_code  <= W'(N - 1);
      r_valid <= 1'b0;
      r_drop  <= 1'b0;
`ifdef RR_ARB_EN
      r_ptr   <= '0;
`endif
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_set;
      r_drop <= |(w_set & r_pend & ~w_clr);
      if (w_load) begin
        r_code  <= w_sel;
        r_valid <= 1'b1;
`ifdef RR_ARB_EN
        r_ptr   <= w_sel + W'(1);
`endif
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;  // code_o keeps its last value while idle
      end
    end
  end

  assign code_o  = r_code;
  assign valid_o = r_valid;
  assign drop_o  = r_drop;
  assign busy_o  = (|r_pend) || r_valid;

endmodule

// File: tb/tb_req_encoder.sv
// Directed bench for req_encoder. Expectations for the round-robin sequence
// follow the RR_ARB_EN define so the same bench covers both builds.
module tb_req_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [1:0] code_o;
  logic       valid_o;
  logic       ready_i;
  logic       drop_o;
  logic       busy_o;

  int n_total = 0;
  int n_bad   = 0;

  req_encoder #(.N(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .code_o  (code_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .drop_o  (drop_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; req = 4'b0000; ready_i = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Check valid_o and code_o together.
  task automatic chk_vc(input string tag, input logic v, input logic [1:0] c);
    check({tag, ".valid"}, {7'd0, valid_o}, {7'd0, v});
    check({tag, ".code"},  {6'd0, code_o},  {6'd0, c});
  endtask

  initial begin
    // 1: reset with all requests high; nothing captured
    rst = 1'b1; en = 1'b1; req = 4'b1111; ready_i = 1'b1;
    tick();
    tick();
    chk_vc("t1_rst", 1'b0, 2'd3);
    check("t1_busy", {7'd0, busy_o}, 8'd0);
    check("t1_drop", {7'd0, drop_o}, 8'd0);
    rst = 1'b0; req = 4'b0000;
    tick();
    check("t1_nocap", {7'd0, busy_o}, 8'd0);
    check("t1_nocap_v", {7'd0, valid_o}, 8'd0);

    // 2: single request, two-cycle latency, one-cycle valid
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    check("t2_pend_v", {7'd0, valid_o}, 8'd0);
    check("t2_pend_b", {7'd0, busy_o}, 8'd1);
    tick();
    chk_vc("t2_out", 1'b1, 2'd2);
    tick();
    chk_vc("t2_idle", 1'b0, 2'd2);
    check("t2_busy", {7'd0, busy_o}, 8'd0);

    // 3: multi-hot burst drains as 0,1,3
    do_reset();
    req = 4'b1011;
    tick();
    req = 4'b0000;
    check("t3_drop0", {7'd0, drop_o}, 8'd0);
    tick();
    chk_vc("t3_c0", 1'b1, 2'd0);
    check("t3_drop1", {7'd0, drop_o}, 8'd0);
    tick();
    chk_vc("t3_c1", 1'b1, 2'd1);
    tick();
    chk_vc("t3_c3", 1'b1, 2'd3);
    tick();
    check("t3_end_v", {7'd0, valid_o}, 8'd0);
    check("t3_end_b", {7'd0, busy_o}, 8'd0);

    // 4: backpressure holds code 0 for 5 cycles
    do_reset();
    ready_i = 1'b0;
    req = 4'b0011;
    tick();
    req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_vc($sformatf("t4_hold%0d", i), 1'b1, 2'd0);
    end
    ready_i = 1'b1;
    tick();
    chk_vc("t4_c1", 1'b1, 2'd1);
    tick();
    check("t4_end_v", {7'd0, valid_o}, 8'd0);
    check("t4_end_b", {7'd0, busy_o}, 8'd0);

    // 5a: re-request of an already-pending bit coalesces and pulses drop_o
    do_reset();
    ready_i = 1'b0;
    req = 4'b0011;
    tick();
    req = 4'b0000;
    tick();
    chk_vc("t5a_c0", 1'b1, 2'd0);
    req = 4'b0010;
    tick();
    req = 4'b0000;
    check("t5a_drop", {7'd0, drop_o}, 8'd1);
    chk_vc("t5a_frozen", 1'b1, 2'd0);
    tick();
    check("t5a_drop_end", {7'd0, drop_o}, 8'd0);
    ready_i = 1'b1;
    tick();
    chk_vc("t5a_c1", 1'b1, 2'd1);
    tick();
    check("t5a_once_v", {7'd0, valid_o}, 8'd0);
    check("t5a_once_b", {7'd0, busy_o}, 8'd0);

    // 5b: re-request on the loading cycle is kept as a new event
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    req = 4'b0000;
    chk_vc("t5b_first", 1'b1, 2'd1);
    check("t5b_nodrop", {7'd0, drop_o}, 8'd0);
    tick();
    chk_vc("t5b_second", 1'b1, 2'd1);
    tick();
    check("t5b_end_v", {7'd0, valid_o}, 8'd0);
    check("t5b_end_b", {7'd0, busy_o}, 8'd0);

    // en=0: toggling requests are ignored
    do_reset();
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req = (i % 2 == 0) ? 4'b1111 : 4'b0000;
      tick();
      check($sformatf("en0_busy%0d", i), {7'd0, busy_o}, 8'd0);
      check($sformatf("en0_drop%0d", i), {7'd0, drop_o}, 8'd0);
    end
    // pending bits still drain with en=0, and no drop is flagged
    en = 1'b1; ready_i = 1'b0; req = 4'b0110;
    tick();
    en = 1'b0; req = 4'b0000;
    tick();
    chk_vc("en0_c1", 1'b1, 2'd1);
    req = 4'b0100;
    tick();
    req = 4'b0000;
    check("en0_nodrop", {7'd0, drop_o}, 8'd0);
    chk_vc("en0_hold", 1'b1, 2'd1);
    ready_i = 1'b1;
    tick();
    chk_vc("en0_c2", 1'b1, 2'd2);
    tick();
    check("en0_end_b", {7'd0, busy_o}, 8'd0);
    en = 1'b1;

    // 6: all requests held; rotation in RR build, bit 0 forever otherwise
    do_reset();
    req = 4'b1111;
    tick();
    for (int i = 0; i < 8; i++) begin
      logic [1:0] exp_c;
`ifdef RR_ARB_EN
      exp_c = 2'(i % 4);
`else
      exp_c = 2'd0;
`endif
      tick();
      chk_vc($sformatf("t6_seq%0d", i), 1'b1, exp_c);
    end
    // reset mid-stream discards the in-flight code
    rst = 1'b1;
    tick();
    chk_vc("t6_rst", 1'b0, 2'd3);
    check("t6_rst_b", {7'd0, busy_o}, 8'd0);
    req = 4'b0000;
    rst = 1'b0;
    tick();
    check("t6_after_b", {7'd0, busy_o}, 8'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
